// File: rtl/writeback_stage.sv
// Register-writeback stage: registers ALU/LUI results and waits for variable-latency load data.
// Optional load-response timeout is enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_stage #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [6:0]                in_opcode,
   input  logic [2:0]                in_funct3,
   input  logic [4:0]                in_rd,
   input  logic [XLEN-1:0]           in_imm,
   input  logic [XLEN-1:0]           in_res,
   input  logic [$clog2(XLEN/8)-1:0] in_addr_lo,
   input  logic                      mem_rsp_valid,
   input  logic [XLEN-1:0]           mem_rsp_data,
   output logic [4:0]                reg_wr,
   output logic [XLEN-1:0]           reg_wr_data,
   output logic                      pend_valid,
   output logic [4:0]                pend_rd,
   output logic                      err_misalign,
   output logic                      err_rsp,
   output logic                      err_timeout
);

   localparam int AW = $clog2(XLEN/8);

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   if (!(XLEN == 32 || XLEN == 64) || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("writeback_stage: XLEN must be 32 or 64 and TIMEOUT_CYCLES at least 1");
   end

   typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

   state_t          state_q, state_d;
   logic [4:0]      reg_wr_q, reg_wr_d;
   logic [XLEN-1:0] reg_wr_data_q, reg_wr_data_d;
   logic [4:0]      pend_rd_q, pend_rd_d;
   logic [2:0]      pend_f3_q, pend_f3_d;
   logic [AW-1:0]   pend_lo_q, pend_lo_d;
   logic            err_misalign_q, err_misalign_d;
   logic            err_rsp_q, err_rsp_d;
   logic            err_timeout_q, err_timeout_d;

`ifdef WB_LOAD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   function automatic logic load_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd5: ok = 1'b1;
         3'd3, 3'd6:                   ok = (XLEN == 64);
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // funct3[1:0] encodes access size: byte, half, word, double
   function automatic logic load_misaligned(input logic [2:0] f3, input logic [AW-1:0] lo);
      logic bad;
      case (f3[1:0])
         2'd1:    bad = lo[0];
         2'd2:    bad = |lo[1:0];
         2'd3:    bad = |lo;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   // funct3[2] set means zero-extend (LBU/LHU/LWU)
   function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] word,
                                                   input logic [AW-1:0] lo);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] ext;
      sh = word >> {lo, 3'b000};
      case (f3[1:0])
         2'd0: begin
            if (f3[2]) ext = XLEN'(sh[7:0]);
            else       ext = XLEN'($signed(sh[7:0]));
         end
         2'd1: begin
            if (f3[2]) ext = XLEN'(sh[15:0]);
            else       ext = XLEN'($signed(sh[15:0]));
         end
         2'd2: begin
            if (f3[2]) ext = XLEN'(sh[31:0]);
            else       ext = XLEN'($signed(sh[31:0]));
         end
         default: ext = sh;
      endcase
      return ext;
   endfunction

   always_comb begin
      state_d        = state_q;
      reg_wr_d       = 5'd0;
      reg_wr_data_d  = '0;
      pend_rd_d      = pend_rd_q;
      pend_f3_d      = pend_f3_q;
      pend_lo_d      = pend_lo_q;
      err_misalign_d = 1'b0;
      err_rsp_d      = err_rsp_q;
      err_timeout_d  = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      tmo_cnt_d      = tmo_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (mem_rsp_valid) err_rsp_d = 1'b1;
            if (in_valid) begin
               case (in_opcode)
                  OP_REG, OP_IMM, OP_JAL, OP_JALR, OP_AUIPC: begin
                     if (in_rd != 5'd0) begin
                        reg_wr_d      = in_rd;
                        reg_wr_data_d = in_res;
                     end
                  end
                  OP_LUI: begin
                     if (in_rd != 5'd0) begin
                        reg_wr_d      = in_rd;
                        reg_wr_data_d = in_imm;
                     end
                  end
                  OP_LOAD: begin
                     if (load_legal(in_funct3)) begin
                        if (load_misaligned(in_funct3, in_addr_lo)) begin
                           err_misalign_d = 1'b1;
                        end else begin
                           state_d   = WAIT_MEM;
                           pend_rd_d = in_rd;
                           pend_f3_d = in_funct3;
                           pend_lo_d = in_addr_lo;
`ifdef WB_LOAD_TIMEOUT_EN
                           tmo_cnt_d = '0;
`endif
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
         WAIT_MEM: begin
            // A response arriving on the timeout cycle still completes the load
            if (mem_rsp_valid) begin
               state_d = IDLE;
               if (pend_rd_q != 5'd0) begin
                  reg_wr_d      = pend_rd_q;
                  reg_wr_data_d = load_extend(pend_f3_q, mem_rsp_data, pend_lo_q);
               end
            end
`ifdef WB_LOAD_TIMEOUT_EN
            else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d       = IDLE;
               err_timeout_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         reg_wr_q       <= 5'd0;
         reg_wr_data_q  <= '0;
         pend_rd_q      <= 5'd0;
         pend_f3_q      <= 3'd0;
         pend_lo_q      <= '0;
         err_misalign_q <= 1'b0;
         err_rsp_q      <= 1'b0;
         err_timeout_q  <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
         tmo_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         reg_wr_q       <= reg_wr_d;
         reg_wr_data_q  <= reg_wr_data_d;
         pend_rd_q      <= pend_rd_d;
         pend_f3_q      <= pend_f3_d;
         pend_lo_q      <= pend_lo_d;
         err_misalign_q <= err_misalign_d;
         err_rsp_q      <= err_rsp_d;
         err_timeout_q  <= err_timeout_d;
`ifdef WB_LOAD_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
`endif
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign pend_valid   = (state_q == WAIT_MEM);
   assign pend_rd      = pend_valid ? pend_rd_q : 5'd0;
   assign reg_wr       = reg_wr_q;
   assign reg_wr_data  = reg_wr_data_q;
   assign err_misalign = err_misalign_q;
   assign err_rsp      = err_rsp_q;
   assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench driving an XLEN=32 and an XLEN=64 writeback_stage from shared stimulus;
// the 32-bit instance sees the low bits of the data buses and address offset.
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [63:0] in_imm;
   logic [63:0] in_res;
   logic [2:0]  in_addr_lo;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;

   logic        in_ready_a, pend_valid_a, err_misalign_a, err_rsp_a, err_timeout_a;
   logic [4:0]  reg_wr_a, pend_rd_a;
   logic [31:0] reg_wr_data_a;
   logic        in_ready_b, pend_valid_b, err_misalign_b, err_rsp_b, err_timeout_b;
   logic [4:0]  reg_wr_b, pend_rd_b;
   logic [63:0] reg_wr_data_b;

   int n_assert = 0;
   int n_fail   = 0;

   writeback_stage #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_imm(in_imm[31:0]), .in_res(in_res[31:0]), .in_addr_lo(in_addr_lo[1:0]),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]),
      .reg_wr(reg_wr_a), .reg_wr_data(reg_wr_data_a), .pend_valid(pend_valid_a),
      .pend_rd(pend_rd_a), .err_misalign(err_misalign_a), .err_rsp(err_rsp_a),
      .err_timeout(err_timeout_a)
   );

   writeback_stage #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_imm(in_imm), .in_res(in_res), .in_addr_lo(in_addr_lo),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .reg_wr(reg_wr_b), .reg_wr_data(reg_wr_data_b), .pend_valid(pend_valid_b),
      .pend_rd(pend_rd_b), .err_misalign(err_misalign_b), .err_rsp(err_rsp_b),
      .err_timeout(err_timeout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [63:0] imm, input logic [63:0] res, input logic [2:0] lo);
      in_valid   = 1'b1;
      in_opcode  = op;
      in_funct3  = f3;
      in_rd      = rd;
      in_imm     = imm;
      in_res     = res;
      in_addr_lo = lo;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_rd = '0;
      in_imm = '0; in_res = '0; in_addr_lo = '0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0;

      tick();
      check_output("rst_reg_wr", reg_wr_a, 0);
      check_output("rst_wr_data", reg_wr_data_a, 0);
      check_output("rst_pend_valid", pend_valid_a, 0);
      check_output("rst_pend_rd", pend_rd_a, 0);
      check_output("rst_in_ready", in_ready_a, 1);
      check_output("rst_errs", {err_misalign_a, err_rsp_a, err_timeout_a}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // ADD, LUI back to back, then rd=0 and an unsupported opcode
      apply_stimulus(7'b0110011, 3'd0, 5'd5, 64'd0, 64'h1234, 3'd0);
      tick();
      check_output("add_reg_wr", reg_wr_a, 5);
      check_output("add_data32", reg_wr_data_a, 64'h1234);
      check_output("add_data64", reg_wr_data_b, 64'h1234);
      apply_stimulus(7'b0110111, 3'd0, 5'd9, 64'hFFFF_FFFF_FFFF_F000, 64'h77, 3'd0);
      tick();
      check_output("lui_reg_wr", reg_wr_a, 9);
      check_output("lui_data32", reg_wr_data_a, 64'hFFFF_F000);
      check_output("lui_data64", reg_wr_data_b, 64'hFFFF_FFFF_FFFF_F000);
      apply_stimulus(7'b0010011, 3'd0, 5'd0, 64'd0, 64'h55, 3'd0);
      tick();
      check_output("rd0_reg_wr", reg_wr_a, 0);
      check_output("rd0_data", reg_wr_data_a, 0);
      apply_stimulus(7'b1110011, 3'd0, 5'd4, 64'd0, 64'h99, 3'd0);
      tick();
      check_output("badop_reg_wr", reg_wr_b, 0);
      check_output("badop_data", reg_wr_data_b, 0);
      in_valid = 1'b0;
      tick();
      check_output("idle_reg_wr", reg_wr_a, 0);

      // LB rd=3 offset 2, response three cycles after accept
      apply_stimulus(7'b0000011, 3'd0, 5'd3, 64'd0, 64'd0, 3'd2);
      tick();
      in_valid = 1'b0;
      check_output("lb_pend_valid", pend_valid_a, 1);
      check_output("lb_pend_rd", pend_rd_a, 3);
      check_output("lb_in_ready", in_ready_a, 0);
      check_output("lb_no_wr", reg_wr_a, 0);
      tick();
      tick();
      check_output("lb_still_pend", pend_rd_b, 3);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_0080_0000;
      #1;
      check_output("lb_rsp_in_ready", in_ready_a, 0);
      // accept LHU in the same cycle the LB write appears
      tick();
      mem_rsp_valid = 1'b0;
      check_output("lb_reg_wr", reg_wr_a, 3);
      check_output("lb_data32", reg_wr_data_a, 64'hFFFF_FF80);
      check_output("lb_data64", reg_wr_data_b, 64'hFFFF_FFFF_FFFF_FF80);
      check_output("lb_done_ready", in_ready_a, 1);
      apply_stimulus(7'b0000011, 3'd5, 5'd6, 64'd0, 64'd0, 3'd2);
      tick();
      in_valid = 1'b0;
      check_output("lhu_reg_wr_off", reg_wr_a, 0);
      check_output("lhu_pend_rd", pend_rd_a, 6);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_ABCD_1234;
      tick();
      mem_rsp_valid = 1'b0;
      check_output("lhu_reg_wr", reg_wr_a, 6);
      check_output("lhu_data32", reg_wr_data_a, 64'h0000_ABCD);
      check_output("lhu_data64", reg_wr_data_b, 64'h0000_ABCD);
      tick();
      check_output("lhu_one_cycle", reg_wr_a, 0);

      // LWU offset 4: legal on RV64, illegal funct3 on RV32
      apply_stimulus(7'b0000011, 3'd6, 5'd7, 64'd0, 64'd0, 3'd4);
      tick();
      in_valid = 1'b0;
      check_output("lwu32_no_pend", pend_valid_a, 0);
      check_output("lwu32_ready", in_ready_a, 1);
      check_output("lwu64_pend_rd", pend_rd_b, 7);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hDEAD_BEEF_0000_0000;
      tick();
      mem_rsp_valid = 1'b0;
      check_output("lwu64_reg_wr", reg_wr_b, 7);
      check_output("lwu64_data", reg_wr_data_b, 64'h0000_0000_DEAD_BEEF);
      check_output("lwu32_reg_wr", reg_wr_a, 0);
      check_output("lwu32_err_rsp", err_rsp_a, 1);
      check_output("lwu64_err_rsp", err_rsp_b, 0);

      // stray response on RV64, then misaligned LH on both
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      check_output("stray_err_rsp64", err_rsp_b, 1);
      check_output("stray_no_wr", reg_wr_b, 0);
      apply_stimulus(7'b0000011, 3'd1, 5'd2, 64'd0, 64'd0, 3'd1);
      tick();
      in_valid = 1'b0;
      check_output("mis_pulse32", err_misalign_a, 1);
      check_output("mis_pulse64", err_misalign_b, 1);
      check_output("mis_no_wr", reg_wr_a, 0);
      check_output("mis_no_pend", pend_valid_a, 0);
      tick();
      check_output("mis_clear", err_misalign_a, 0);
      check_output("err_rsp_sticky32", err_rsp_a, 1);
      check_output("err_rsp_sticky64", err_rsp_b, 1);

      // LW with no response
      apply_stimulus(7'b0000011, 3'd2, 5'd10, 64'd0, 64'd0, 3'd0);
      tick();
      in_valid = 1'b0;
      check_output("lw_pend", pend_valid_a, 1);
`ifdef WB_LOAD_TIMEOUT_EN
      tick();
      tick();
      tick();
      check_output("tmo_still_pend", pend_valid_a, 1);
      check_output("tmo_not_yet", err_timeout_a, 0);
      tick();
      check_output("tmo_idle", pend_valid_a, 0);
      check_output("tmo_pulse32", err_timeout_a, 1);
      check_output("tmo_pulse64", err_timeout_b, 1);
      check_output("tmo_no_wr", reg_wr_a, 0);
      tick();
      check_output("tmo_clear", err_timeout_a, 0);
`else
      for (int i = 0; i < 8; i++) tick();
      check_output("hold_pend32", pend_valid_a, 1);
      check_output("hold_pend64", pend_valid_b, 1);
      check_output("hold_no_tmo", err_timeout_a, 0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_1122_3344;
      tick();
      mem_rsp_valid = 1'b0;
      check_output("late_lw_reg_wr", reg_wr_a, 10);
      check_output("late_lw_data64", reg_wr_data_b, 64'h1122_3344);
`endif

      // reset while a load is pending
      apply_stimulus(7'b0000011, 3'd4, 5'd12, 64'd0, 64'd0, 3'd1);
      tick();
      in_valid = 1'b0;
      check_output("lbu_pend_rd", pend_rd_a, 12);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_pend", pend_valid_a, 0);
      check_output("mid_rst_pend_rd", pend_rd_b, 0);
      check_output("mid_rst_err_rsp", err_rsp_a, 0);
      check_output("mid_rst_reg_wr", reg_wr_b, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check_output("post_rst_ready32", in_ready_a, 1);
      check_output("post_rst_ready64", in_ready_b, 1);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_0000_00FF;
      tick();
      mem_rsp_valid = 1'b0;
      check_output("stale_err_rsp", err_rsp_a, 1);
      check_output("stale_no_wr", reg_wr_a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
